// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage controller of the pipelined MIPS core.
package mem_stage_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    localparam int TIMEOUT_MIN = 1;
    localparam int TIMEOUT_MAX = 1023;

    // Bits needed to hold values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM stage: drives a req/ack data memory, stalls upstream while an access is
// outstanding, and registers the MEM/WB fields (with bubbles during the stall).
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_mem_wr,
    input  logic        i_mem_rd,
    input  logic [31:0] i_alu_out,
    input  logic [31:0] i_data_bus_b,
    input  logic        i_reg_wr,
    input  logic [1:0]  i_mem_to_reg,
    input  logic [4:0]  i_register_rd,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_stall,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_alu_out,
    output logic [31:0] o_mem_data,
    output logic        o_reg_wr,
    output logic [1:0]  o_mem_to_reg,
    output logic [4:0]  o_register_rd,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int            CW     = clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(TIMEOUT);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic        w_is_mem;
    logic        w_misalign;
    logic        w_access;
    logic        w_req;
    logic        w_timeout_hit;
    logic        w_bubble;
    logic [31:0] w_load_data;

    logic [31:0] w_wb_pc;
    logic [31:0] w_wb_alu;
    logic [31:0] w_wb_data;
    logic        w_wb_regwr;
    logic [1:0]  w_wb_m2r;
    logic [4:0]  w_wb_rd;
    logic        w_wb_mis;
    logic        w_wb_berr;

    assign w_is_mem    = i_mem_rd | i_mem_wr;
    assign w_misalign  = w_is_mem & (i_alu_out[1:0] != 2'b00);
    assign w_access    = w_is_mem & (i_alu_out[1:0] == 2'b00);
    // A combined read+write is performed as a write, so no load data returns.
    assign w_load_data = (i_mem_rd & ~i_mem_wr) ? i_mem_rdata : 32'h0;

    assign w_req         = reset & (((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY));
    assign w_timeout_hit = (r_state == ST_BUSY) & (r_cnt == CNT_TC) & ~i_mem_ack;

    assign o_mem_req   = w_req;
    assign o_mem_we    = i_mem_wr;
    assign o_mem_addr  = i_alu_out;
    assign o_mem_wdata = i_data_bus_b;
    assign o_stall     = w_req & ~i_mem_ack & ~w_timeout_hit;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bubble    = 1'b0;
        w_wb_pc     = i_pc_plus4;
        w_wb_alu    = i_alu_out;
        w_wb_data   = 32'h0;
        w_wb_regwr  = i_reg_wr;
        w_wb_m2r    = i_mem_to_reg;
        w_wb_rd     = i_register_rd;
        w_wb_mis    = 1'b0;
        w_wb_berr   = 1'b0;

        if (r_state == ST_IDLE) begin
            if (w_access) begin
                if (i_mem_ack) begin
                    w_wb_data = w_load_data;
                end else begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CW'(1);
                    w_bubble    = 1'b1;
                end
            end else if (w_misalign) begin
                w_wb_regwr = 1'b0;
                w_wb_mis   = 1'b1;
            end
        end else begin
            if (i_mem_ack) begin
                w_wb_data   = w_load_data;
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else if (w_timeout_hit) begin
                w_wb_regwr  = 1'b0;
                w_wb_berr   = 1'b1;
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
                w_bubble  = 1'b1;
            end
        end

        // Bubble: nothing retires; zero the payload so WB sees a clean NOP.
        if (w_bubble) begin
            w_wb_pc    = 32'h0;
            w_wb_alu   = 32'h0;
            w_wb_data  = 32'h0;
            w_wb_regwr = 1'b0;
            w_wb_m2r   = M2R_ALU;
            w_wb_rd    = 5'd0;
            w_wb_mis   = 1'b0;
            w_wb_berr  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            o_pc_plus4    <= 32'h0;
            o_alu_out     <= 32'h0;
            o_mem_data    <= 32'h0;
            o_reg_wr      <= 1'b0;
            o_mem_to_reg  <= 2'b00;
            o_register_rd <= 5'd0;
            o_misalign    <= 1'b0;
            o_bus_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            o_pc_plus4    <= w_wb_pc;
            o_alu_out     <= w_wb_alu;
            o_mem_data    <= w_wb_data;
            o_reg_wr      <= w_wb_regwr;
            o_mem_to_reg  <= w_wb_m2r;
            o_register_rd <= w_wb_rd;
            o_misalign    <= w_wb_mis;
            o_bus_err     <= w_wb_berr;
        end
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller sitting between the EX/MEM pipeline register and the MEM/WB pipeline register of the pipelined MIPS core. It consumes the EX/MEM register outputs and performs loads and stores against a variable-latency data memory over a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and registers the result into the MEM/WB fields. Misaligned accesses and memory timeouts are flagged rather than performed.

## Interface
- TIMEOUT, 255: max cycles to wait for mem_ack before abandoning an access (1..1023)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- PC_plus4_in  in  32  PC+4 from EX/MEM
- MemWr_in  in  1  store request from EX/MEM
- MemRd_in  in  1  load request from EX/MEM
- ALUOut_in  in  32  effective address / ALU result
- DataBus_B_in  in  32  store data
- RegWr_in  in  1  register write enable
- MemToReg_in  in  2  WB mux select
- RegisterRd_in  in  5  destination register
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address (ALUOut_in)
- mem_wdata  out  32  store data
- mem_ack  in  1  memory completes access this cycle
- mem_rdata  in  32  load data, valid with mem_ack
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- PC_plus4_out, ALUOut_out, MemData_out  out  32 each  MEM/WB data fields
- RegWr_out  out  1, MemToReg_out  out  2, RegisterRd_out  out  5  MEM/WB control fields
- misalign  out  1  registered: instruction now in WB had ALUOut_in[1:0]!=0 on a memory access
- bus_err  out  1  registered: instruction now in WB timed out

## Operation
- States: IDLE, BUSY. access = (MemRd_in | MemWr_in) & ALUOut_in[1:0]==0.
- mem_req = reset & ((IDLE & access) | BUSY); mem_we = MemWr_in; mem_addr/mem_wdata driven from inputs (stable because EX/MEM frozen by stall).
- stall = mem_req & ~mem_ack & ~timeout_hit.
- IDLE, no access: MEM/WB fields load from inputs, MemData_out <= 0. Stays IDLE.
- IDLE, access, mem_ack=1: zero-wait completion; MEM/WB load, MemData_out <= mem_rdata if load else 0. Stays IDLE.
- IDLE, access, mem_ack=0: -> BUSY, counter <= 1, MEM/WB loads a bubble (RegWr_out=0, misalign=0, bus_err=0, other fields don't-care but set 0).
- BUSY, mem_ack=1: complete as above, -> IDLE.
- BUSY, counter==TIMEOUT, no ack: timeout_hit; MEM/WB loads instruction with RegWr_out=0, bus_err=1; -> IDLE. Else counter++ and bubble.
- Misaligned memory op: no request, no stall; MEM/WB loads with RegWr_out=0, misalign=1.
- MemRd_in & MemWr_in both 1: performed as a write; MemData_out=0.
- mem_ack while mem_req=0: ignored.

## Timing
- Non-memory op: 1 cycle, results visible on MEM/WB outputs at next edge.
- Memory op with ack after N wait cycles (N>=0): stall high N cycles, result in MEM/WB at edge N+1; bubbles in MEM/WB during stall.
- Timeout: stall high exactly TIMEOUT cycles.
- Reset (reset=0) at any edge: state IDLE, counter 0, all outputs 0; mem_req and stall forced 0 combinationally while reset=0, including mid-BUSY (access abandoned).

## Structure
- Shared package: state encoding (IDLE/BUSY), MemToReg encodings, counter width function clog2(TIMEOUT+1).
- No sub-module; FSM, counter and MEM/WB register in one block.

## Test plan
- ADD, RegWr_in=1, Rd=5, ALUOut=0x1234: next edge RegWr_out=1, RegisterRd_out=5, ALUOut_out=0x1234, stall never asserted.
- Load 0x100, ack same cycle, rdata=0xDEADBEEF: stall=0, MemData_out=0xDEADBEEF next edge.
- Store 0x200 data 0xA5A5A5A5, ack after 3 cycles: mem_req/mem_we=1 4 cycles, stall=1 3 cycles, 3 bubbles (RegWr_out=0), then store result.
- Load 0x102: no mem_req, misalign=1, RegWr_out=0 next edge.
- TIMEOUT=4, load with no ack: stall 4 cycles, then bus_err=1, RegWr_out=0, state IDLE.
- Reset low during BUSY cycle 2: mem_req/stall drop immediately, all outputs 0 after edge, next load starts fresh.
